// File: rtl/clock_stepper_pkg.sv
// Shared types and helpers for the CPU clock stepper.
package clock_stepper_pkg;

    // Clock source selected by the stepper FSM.
    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_stepper_if.sv
// Board-side signals of the clock stepper: switch inputs and CPU clock/status outputs.
interface clock_stepper_if #(
    parameter int COUNT_W = 32
);
    logic               step_btn;
    logic               auto_en;
    logic               cpu_clk;
    logic               cpu_tick;
    logic [COUNT_W-1:0] cycle_count;
    logic               btn_clean;
    logic               auto_active;

    // Board / bench side: drives the switches, watches the clock.
    modport master (
        output step_btn, auto_en,
        input  cpu_clk, cpu_tick, cycle_count, btn_clean, auto_active
    );

    // Stepper side.
    modport slave (
        input  step_btn, auto_en,
        output cpu_clk, cpu_tick, cycle_count, btn_clean, auto_active
    );
endinterface

// File: rtl/clock_stepper_button_debouncer.sv
// Synchronizes a raw push-button and only follows it once it has stayed
// at a new level for DEBOUNCE_CYCLES consecutive board cycles.
module button_debouncer
    import clock_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean
);
    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             raw_m;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous key.
    always_ff @(posedge clock) begin
        if (reset) begin
            raw_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            raw_m <= raw;
            btn_s <= raw_m;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (btn_s == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            clean <= btn_s;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/clock_stepper.sv
// CPU clock generator: one cycle per debounced key press in manual mode,
// a divided board clock in auto mode. Mode changes only happen while the
// CPU clock is low so no phase is ever shorter than one board cycle.
module clock_stepper
    import clock_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HALF_PERIOD     = 50000000,
    parameter int COUNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    clock_stepper_if.slave   bus
);
    localparam int               DIV_W    = cnt_width(HALF_PERIOD);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);

    state_t             state;
    logic               auto_m;
    logic               auto_s;
    logic               btn_clean;
    logic               arm;
    logic [DIV_W-1:0]   div;
    logic               cpu_clk;
    logic               cpu_tick;
    logic [COUNT_W-1:0] cycle_count;
    logic               auto_active;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (bus.step_btn),
        .clean (btn_clean)
    );

    // Two-flop synchronizer for the mode switch.
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_m <= 1'b0;
            auto_s <= 1'b0;
        end else begin
            auto_m <= bus.auto_en;
            auto_s <= auto_m;
        end
    end

    // Mode FSM, divider, arm flag, rising-edge tick and cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_MANUAL;
            arm         <= 1'b0;
            div         <= '0;
            cpu_clk     <= 1'b0;
            cpu_tick    <= 1'b0;
            cycle_count <= '0;
            auto_active <= 1'b0;
        end else begin
            cpu_tick <= 1'b0;
            case (state)
                ST_MANUAL: begin
                    if (auto_s && !cpu_clk) begin
                        state       <= ST_AUTO;
                        auto_active <= 1'b1;
                        arm         <= 1'b0;
                        div         <= '0;
                    end else begin
                        // Arm only after a released key, so a key held through
                        // a mode change cannot produce a clock edge.
                        if (!btn_clean) arm <= 1'b1;
                        cpu_clk <= btn_clean & arm;
                        if (btn_clean && arm && !cpu_clk) begin
                            cpu_tick    <= 1'b1;
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end
                end
                ST_AUTO: begin
                    if (!auto_s && !cpu_clk) begin
                        state       <= ST_MANUAL;
                        auto_active <= 1'b0;
                        arm         <= 1'b0;
                    end else if (div == DIV_LAST) begin
                        // A pending switch to manual waits for this toggle when high.
                        div     <= '0;
                        cpu_clk <= ~cpu_clk;
                        if (!cpu_clk) begin
                            cpu_tick    <= 1'b1;
                            cycle_count <= cycle_count + 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= ST_MANUAL;
            endcase
        end
    end

    assign bus.cpu_clk     = cpu_clk;
    assign bus.cpu_tick    = cpu_tick;
    assign bus.cycle_count = cycle_count;
    assign bus.btn_clean   = btn_clean;
    assign bus.auto_active = auto_active;
endmodule
